// File: rtl/pci_pkg.sv
// rtl/pci_pkg.sv - shared types for the PCI target bridge
package pci_pkg;

    localparam int DW     = 32;
    localparam int BAR_AW = 12;

    typedef enum logic [1:0] {
        IDLE,
        RD_DRAIN,
        RD_ISSUE
    } tgt_state_t;

    typedef enum logic [1:0] {
        APP_NONE,
        APP_WR,
        APP_RD
    } app_mode_t;

    // Posted-write entry; address field follows the BAR window width
    typedef struct packed {
        logic [BAR_AW-1:2] addr;
        logic [DW-1:0]     data;
        logic [3:0]        be;
    } pw_entry_t;

endpackage

// File: rtl/pci_sync_fifo.sv
// rtl/pci_sync_fifo.sv - single-clock FIFO for posted writes
module pci_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [PW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (r_count == (PW+1)'(DEPTH));
    assign empty     = (r_count == '0);
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;
    assign dout      = r_mem[r_rptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
            if (w_do_push && !w_do_pop)
                r_count <= r_count + 1'b1;
            else if (!w_do_push && w_do_pop)
                r_count <= r_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr] <= din;
    end

endmodule

// File: rtl/pci_tgt_bridge.sv
// rtl/pci_tgt_bridge.sv - posted-write / delayed-read target stage between busif and app block
module pci_tgt_bridge
    import pci_pkg::*;
#(
    parameter int AW            = BAR_AW,
    parameter int FIFO_DEPTH    = 4,
    parameter int RETRY_LIMIT   = 14,
    parameter int DISCARD_LIMIT = 1024
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          tgt_enable,
    input  logic          tgt_iswrite,
    input  logic [AW-1:0] tgt_addr,
    input  logic [DW-1:0] tgt_write_val,
    input  logic [3:0]    tgt_be,
    output logic [DW-1:0] tgt_read_val,
    output logic          tgt_done,
    output logic          tgt_retry,
    output logic          app_req,
    output logic          app_we,
    output logic [AW-1:0] app_addr,
    output logic [DW-1:0] app_wdata,
    output logic [3:0]    app_be,
    input  logic          app_ack,
    input  logic [DW-1:0] app_rdata
);

    localparam int CW  = $clog2(RETRY_LIMIT + 1);
    localparam int DCW = $clog2(DISCARD_LIMIT + 1);

    tgt_state_t    r_state;
    tgt_state_t    w_state_nxt;
    app_mode_t     r_mode;

    logic          r_done;
    logic          r_retry;
    logic [DW-1:0] r_read_val;
    logic          r_dr_vld;
    logic          r_dr_cmp;
    logic [AW-1:2] r_dr_addr;
    logic [3:0]    r_dr_be;
    logic [DW-1:0] r_dr_data;
    logic [CW-1:0] r_cnt;
    logic [DCW-1:0] r_disc;

    pw_entry_t     w_push_entry;
    pw_entry_t     w_head;
    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic          w_edge;
    logic          w_dr_match;
    logic          w_rd_ack;
    logic          w_cnt_hit;
    logic          w_discard;
    logic          w_done_nxt;
    logic          w_retry_nxt;
    logic          w_dr_load;
    logic          w_dr_clear;
    logic          w_rv_load;
    logic [DW-1:0] w_rv_nxt;
    logic          w_unused;

    assign w_unused = ^tgt_addr[1:0];

    // A new request is only taken in IDLE and never in the clk that still shows the previous pulse
    assign w_edge     = tgt_enable && !r_done && !r_retry && (r_state == IDLE);
    assign w_dr_match = r_dr_vld && (r_dr_addr == tgt_addr[AW-1:2]) && (r_dr_be == tgt_be);
    assign w_rd_ack   = (r_mode == APP_RD) && app_ack;
    assign w_pop      = (r_mode == APP_WR) && app_ack;
    assign w_cnt_hit  = (r_cnt == CW'(RETRY_LIMIT - 1));
    assign w_discard  = r_dr_cmp && (r_state == IDLE) && (r_disc == DCW'(DISCARD_LIMIT - 1));

    assign w_push_entry.addr = tgt_addr[AW-1:2];
    assign w_push_entry.data = tgt_write_val;
    assign w_push_entry.be   = tgt_be;

    pci_sync_fifo #(
        .WIDTH ($bits(pw_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_pw_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .din   (w_push_entry),
        .dout  (w_head),
        .full  (w_full),
        .empty (w_empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_done_nxt  = 1'b0;
        w_retry_nxt = 1'b0;
        w_push      = 1'b0;
        w_dr_load   = 1'b0;
        w_dr_clear  = 1'b0;
        w_rv_load   = 1'b0;
        w_rv_nxt    = r_dr_data;
        case (r_state)
            IDLE: begin
                if (w_edge) begin
                    if (tgt_iswrite) begin
                        if (w_full) begin
                            w_retry_nxt = 1'b1;
                        end else begin
                            w_push     = 1'b1;
                            w_done_nxt = 1'b1;
                        end
                    end else if (!r_dr_vld) begin
                        w_dr_load   = 1'b1;
                        w_state_nxt = RD_DRAIN;
                    end else if (!w_dr_match) begin
                        w_retry_nxt = 1'b1;
                    end else if (r_dr_cmp) begin
                        w_done_nxt = 1'b1;
                        w_rv_load  = 1'b1;
                        w_dr_clear = 1'b1;
                    end else begin
                        w_state_nxt = (r_mode == APP_RD) ? RD_ISSUE : RD_DRAIN;
                    end
                end
            end
            RD_DRAIN, RD_ISSUE: begin
                if (w_rd_ack) begin
                    w_done_nxt  = 1'b1;
                    w_rv_load   = 1'b1;
                    w_rv_nxt    = app_rdata;
                    w_dr_clear  = 1'b1;
                    w_state_nxt = IDLE;
                end else if (r_dr_cmp) begin
                    // data landed in the same clk the re-attempt was sampled
                    w_done_nxt  = 1'b1;
                    w_rv_load   = 1'b1;
                    w_dr_clear  = 1'b1;
                    w_state_nxt = IDLE;
                end else if (w_cnt_hit) begin
                    w_retry_nxt = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = (r_mode == APP_RD) ? RD_ISSUE : RD_DRAIN;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_done     <= 1'b0;
            r_retry    <= 1'b0;
            r_read_val <= '0;
            r_cnt      <= '0;
            r_disc     <= '0;
            r_dr_vld   <= 1'b0;
            r_dr_cmp   <= 1'b0;
            r_dr_addr  <= '0;
            r_dr_be    <= '0;
            r_dr_data  <= '0;
        end else begin
            r_done  <= w_done_nxt;
            r_retry <= w_retry_nxt;
            if (w_rv_load) r_read_val <= w_rv_nxt;

            if (r_state == IDLE)            r_cnt <= '0;
            else if (r_cnt != CW'(RETRY_LIMIT)) r_cnt <= r_cnt + 1'b1;

            if (!r_dr_cmp)                        r_disc <= '0;
            else if (r_disc != DCW'(DISCARD_LIMIT)) r_disc <= r_disc + 1'b1;

            if (w_dr_load) begin
                r_dr_vld  <= 1'b1;
                r_dr_cmp  <= 1'b0;
                r_dr_addr <= tgt_addr[AW-1:2];
                r_dr_be   <= tgt_be;
            end else if (w_dr_clear || w_discard) begin
                r_dr_vld <= 1'b0;
                r_dr_cmp <= 1'b0;
            end else if (w_rd_ack) begin
                r_dr_cmp  <= 1'b1;
                r_dr_data <= app_rdata;
            end
        end
    end

    // Drain has the port unless the FIFO is empty, so posted writes keep their order around the read
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mode <= APP_NONE;
        end else begin
            case (r_mode)
                APP_NONE: begin
                    if (!w_empty)                   r_mode <= APP_WR;
                    else if (r_dr_vld && !r_dr_cmp) r_mode <= APP_RD;
                end
                APP_WR:  if (app_ack) r_mode <= APP_NONE;
                APP_RD:  if (app_ack) r_mode <= APP_NONE;
                default: r_mode <= APP_NONE;
            endcase
        end
    end

    always_comb begin
        app_req   = (r_mode != APP_NONE);
        app_we    = (r_mode == APP_WR);
        app_addr  = '0;
        app_wdata = '0;
        app_be    = '0;
        if (r_mode == APP_WR) begin
            app_addr  = {w_head.addr, 2'b00};
            app_wdata = w_head.data;
            app_be    = w_head.be;
        end else if (r_mode == APP_RD) begin
            app_addr = {r_dr_addr, 2'b00};
            app_be   = r_dr_be;
        end
    end

    assign tgt_done     = r_done;
    assign tgt_retry    = r_retry;
    assign tgt_read_val = r_read_val;

endmodule

// File: tb/tb_pci_tgt_bridge.sv
// tb/tb_pci_tgt_bridge.sv - directed self-checking bench for pci_tgt_bridge
module tb_pci_tgt_bridge;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        tgt_enable = 1'b0;
    logic        tgt_iswrite = 1'b0;
    logic [11:0] tgt_addr = '0;
    logic [31:0] tgt_write_val = '0;
    logic [3:0]  tgt_be = '0;
    logic [31:0] tgt_read_val;
    logic        tgt_done;
    logic        tgt_retry;
    logic        app_req;
    logic        app_we;
    logic [11:0] app_addr;
    logic [31:0] app_wdata;
    logic [3:0]  app_be;
    logic        app_ack = 1'b0;
    logic [31:0] app_rdata = '0;

    int          n_checks = 0;
    int          n_errors = 0;
    bit          ack_stall = 1'b0;
    int          ack_dly = 0;
    int          wait_cnt = 0;
    bit          log_we[$];
    logic [11:0] log_addr[$];
    logic [31:0] log_data[$];
    logic [3:0]  log_be[$];

    pci_tgt_bridge dut (
        .clk           (clk),
        .rst           (rst),
        .tgt_enable    (tgt_enable),
        .tgt_iswrite   (tgt_iswrite),
        .tgt_addr      (tgt_addr),
        .tgt_write_val (tgt_write_val),
        .tgt_be        (tgt_be),
        .tgt_read_val  (tgt_read_val),
        .tgt_done      (tgt_done),
        .tgt_retry     (tgt_retry),
        .app_req       (app_req),
        .app_we        (app_we),
        .app_addr      (app_addr),
        .app_wdata     (app_wdata),
        .app_be        (app_be),
        .app_ack       (app_ack),
        .app_rdata     (app_rdata)
    );

    always #5 clk = ~clk;

    // App responder: ack_dly+1 clks after app_req rises, logging every completed access
    always @(negedge clk) begin
        app_ack = 1'b0;
        if (!app_req) begin
            wait_cnt = 0;
        end else if (!ack_stall) begin
            if (wait_cnt >= ack_dly) begin
                app_ack  = 1'b1;
                wait_cnt = 0;
                log_we.push_back(app_we);
                log_addr.push_back(app_addr);
                log_data.push_back(app_wdata);
                log_be.push_back(app_be);
            end else begin
                wait_cnt++;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // res: 0 none within budget, 1 done, 2 retry; lat counts negedges until the pulse
    task automatic do_req(input logic wr, input logic [11:0] a, input logic [31:0] d,
                          input logic [3:0] be, input int budget,
                          output int res, output int lat, output logic [31:0] rv);
        tgt_iswrite   = wr;
        tgt_addr      = a;
        tgt_write_val = d;
        tgt_be        = be;
        tgt_enable    = 1'b1;
        res = 0;
        lat = 0;
        rv  = '0;
        for (int i = 1; i <= budget && res == 0; i++) begin
            @(negedge clk);
            if (tgt_done) begin
                res = 1;
                lat = i;
                rv  = tgt_read_val;
            end else if (tgt_retry) begin
                res = 2;
                lat = i;
            end
        end
        tgt_enable = 1'b0;
        @(negedge clk);
    endtask

    function automatic int count_reads(input int from);
        int n = 0;
        for (int i = from; i < log_we.size(); i++) if (!log_we[i]) n++;
        return n;
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          res;
        int          lat;
        int          mark;
        logic [31:0] rv;

        tick(2);
        check("rst_done", tgt_done, 0);
        check("rst_retry", tgt_retry, 0);
        check("rst_app_req", app_req, 0);
        check("rst_read_val", tgt_read_val, 0);
        check("rst_app_addr", app_addr, 0);
        rst = 1'b1;
        tick(2);

        // T1: single posted write
        ack_dly = 0;
        mark = log_we.size();
        do_req(1'b1, 12'h010, 32'hDEADBEEF, 4'hF, 10, res, lat, rv);
        check("t1_res", res, 1);
        check("t1_lat", lat, 1);
        tick(5);
        check("t1_log_n", log_we.size() - mark, 1);
        check("t1_we", log_we[mark], 1);
        check("t1_addr", log_addr[mark], 12'h010);
        check("t1_data", log_data[mark], 32'hDEADBEEF);
        check("t1_be", log_be[mark], 4'hF);

        // T2: FIFO fills with the app stalled; fifth write is retried
        ack_stall = 1'b1;
        mark = log_we.size();
        for (int i = 0; i < 4; i++) begin
            do_req(1'b1, 12'h100 + 12'(4 * i), 32'h1000 + 32'(i), 4'hF, 10, res, lat, rv);
            check($sformatf("t2_w%0d_res", i), res, 1);
        end
        do_req(1'b1, 12'h110, 32'h1004, 4'hF, 10, res, lat, rv);
        check("t2_w4_res", res, 2);
        check("t2_w4_lat", lat, 1);
        check("t2_head_req", app_req, 1);
        check("t2_head_addr", app_addr, 12'h100);
        ack_stall = 1'b0;
        tick(20);
        check("t2_log_n", log_we.size() - mark, 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t2_addr%0d", i), log_addr[mark + i], 12'h100 + 12'(4 * i));
            check($sformatf("t2_data%0d", i), log_data[mark + i], 32'h1000 + 32'(i));
        end

        // T3: read behind two posted writes completes without retry
        ack_dly   = 1;
        app_rdata = 32'hCAFE0010;
        mark = log_we.size();
        do_req(1'b1, 12'h200, 32'hA0, 4'hF, 10, res, lat, rv);
        do_req(1'b1, 12'h204, 32'hA1, 4'h3, 10, res, lat, rv);
        do_req(1'b0, 12'h010, 32'h0, 4'hF, 40, res, lat, rv);
        check("t3_res", res, 1);
        check("t3_rdata", rv, 32'hCAFE0010);
        tick(3);
        check("t3_log_n", log_we.size() - mark, 3);
        check("t3_op0", {log_we[mark], 4'h0, log_addr[mark]}, {1'b1, 4'h0, 12'h200});
        check("t3_op1", {log_we[mark + 1], 4'h0, log_addr[mark + 1]}, {1'b1, 4'h0, 12'h204});
        check("t3_op2", {log_we[mark + 2], 4'h0, log_addr[mark + 2]}, {1'b0, 4'h0, 12'h010});

        // T4: slow read becomes a delayed transaction
        ack_dly   = 29;
        app_rdata = 32'h20202020;
        mark = log_we.size();
        do_req(1'b0, 12'h020, 32'h0, 4'hF, 40, res, lat, rv);
        check("t4_first_res", res, 2);
        check("t4_first_lat", lat, 15);
        do_req(1'b0, 12'h020, 32'h0, 4'hF, 40, res, lat, rv);
        check("t4_second_res", res, 2);
        tick(5);
        check("t4_reads_issued", count_reads(mark), 1);
        app_rdata = 32'h0;
        do_req(1'b0, 12'h020, 32'h0, 4'hF, 40, res, lat, rv);
        check("t4_claim_res", res, 1);
        check("t4_claim_lat", lat, 1);
        check("t4_claim_data", rv, 32'h20202020);
        tick(5);
        check("t4_no_reissue", count_reads(mark), 1);
        check("t4_app_idle", app_req, 0);

        // T5: mismatching read retried, writes pass the pending delayed read
        ack_stall = 1'b1;
        ack_dly   = 0;
        mark = log_we.size();
        do_req(1'b0, 12'h020, 32'h0, 4'hF, 40, res, lat, rv);
        check("t5_dr_res", res, 2);
        do_req(1'b0, 12'h024, 32'h0, 4'hF, 10, res, lat, rv);
        check("t5_other_res", res, 2);
        check("t5_other_lat", lat, 1);
        do_req(1'b1, 12'h030, 32'h30303030, 4'hF, 10, res, lat, rv);
        check("t5_wr_res", res, 1);
        app_rdata = 32'h0BADF00D;
        ack_stall = 1'b0;
        tick(10);
        check("t5_log_n", log_we.size() - mark, 2);
        check("t5_op0", {log_we[mark], 4'h0, log_addr[mark]}, {1'b0, 4'h0, 12'h020});
        check("t5_op1", {log_we[mark + 1], 4'h0, log_addr[mark + 1]}, {1'b1, 4'h0, 12'h030});
        do_req(1'b0, 12'h020, 32'h0, 4'hF, 10, res, lat, rv);
        check("t5_claim_data", rv, 32'h0BADF00D);

        // T6: reset while the read is on the app port and two writes are queued
        ack_stall = 1'b1;
        do_req(1'b0, 12'h040, 32'h0, 4'hF, 40, res, lat, rv);
        check("t6_rd_res", res, 2);
        do_req(1'b1, 12'h044, 32'h44, 4'hF, 10, res, lat, rv);
        check("t6_w0_res", res, 1);
        do_req(1'b1, 12'h048, 32'h48, 4'hF, 10, res, lat, rv);
        check("t6_w1_res", res, 1);
        tgt_iswrite = 1'b0;
        tgt_addr    = 12'h040;
        tgt_be      = 4'hF;
        tgt_enable  = 1'b1;
        tick(3);
        check("t6_issue_req", {app_req, app_we}, 2'b10);
        #2;
        rst = 1'b0;
        #1;
        check("t6_async_req", app_req, 0);
        tgt_enable = 1'b0;
        ack_stall  = 1'b0;
        ack_dly    = 0;
        tick(1);
        rst = 1'b1;
        mark = log_we.size();
        tick(6);
        check("t6_fifo_empty", log_we.size() - mark, 0);
        check("t6_app_idle", app_req, 0);
        do_req(1'b1, 12'h050, 32'h55, 4'hF, 10, res, lat, rv);
        check("t6_wr_res", res, 1);
        tick(5);
        check("t6_log_n", log_we.size() - mark, 1);
        check("t6_wr_addr", log_addr[mark], 12'h050);

        // Completed delayed read left unclaimed is discarded
        ack_dly   = 20;
        app_rdata = 32'h60606060;
        mark = log_we.size();
        do_req(1'b0, 12'h060, 32'h0, 4'hF, 40, res, lat, rv);
        check("disc_first_res", res, 2);
        tick(15);
        check("disc_first_read", count_reads(mark), 1);
        tick(1040);
        ack_dly   = 0;
        app_rdata = 32'h61616161;
        do_req(1'b0, 12'h060, 32'h0, 4'hF, 40, res, lat, rv);
        check("disc_reread_res", res, 1);
        check("disc_reread_data", rv, 32'h61616161);
        check("disc_new_read", count_reads(mark), 2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
